// File: rtl/receiver_if.sv
// Receiver bus interface: serial line, consumer handshake and status flags.
// The master modport is the side that drives the line and consumes bytes;
// the slave modport is the receiver itself.
interface receiver_if;
    logic       rx_enable;
    logic       rx_data_in;
    logic       rx_ready;
    logic [7:0] rx_data_out;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    logic       done;

    modport master (
        output rx_enable, rx_data_in, rx_ready,
        input  rx_data_out, rx_valid, parity_err, frame_err, overrun, busy, done
    );

    modport slave (
        input  rx_enable, rx_data_in, rx_ready,
        output rx_data_out, rx_valid, parity_err, frame_err, overrun, busy, done
    );
endinterface

// File: rtl/receiver.sv
// Same-clock serial receiver: start, 8 data bits LSB first, even parity, stop.
// One bit per tx_clk edge, no oversampling. The received byte is held with a
// valid/ready handshake; a frame finishing while the holding register is still
// occupied is dropped and flagged as overrun.
// Optional feature macro: RX_PARITY_CHECK_EN (parity checking; when undefined
// the parity bit is still consumed but parity_err stays 0).
module receiver (
    input  logic      tx_clk,
    input  logic      rst_n,
    receiver_if.slave bus
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t              state;
    logic [CNT_W-1:0]    count;
    logic [DATA_W-1:0]   shift_reg;
    logic                xfer_c;
    logic                parity_err_c;
`ifdef RX_PARITY_CHECK_EN
    logic                parity_bit;
`endif

    // A transfer happens whenever the consumer takes the held byte.
    assign xfer_c = bus.rx_valid && bus.rx_ready;

    // Parity mismatch for the frame currently sitting in the shift register.
`ifdef RX_PARITY_CHECK_EN
    assign parity_err_c = parity_bit ^ (^shift_reg);
`else
    assign parity_err_c = 1'b0;
`endif

    // Frame FSM with registered outputs and holding-register handshake.
    always_ff @(posedge tx_clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            count           <= CNT_W'(0);
            shift_reg       <= DATA_W'(0);
`ifdef RX_PARITY_CHECK_EN
            parity_bit      <= 1'b0;
`endif
            bus.rx_data_out <= DATA_W'(0);
            bus.rx_valid    <= 1'b0;
            bus.parity_err  <= 1'b0;
            bus.frame_err   <= 1'b0;
            bus.overrun     <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            bus.done <= 1'b0;

            // Consumer took the byte; a frame load at this edge overrides below.
            if (xfer_c) begin
                bus.rx_valid <= 1'b0;
                bus.overrun  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.rx_enable && !bus.rx_data_in) begin
                        state    <= DATA;
                        count    <= CNT_W'(0);
                        bus.busy <= 1'b1;
                    end
                end
                DATA: begin
                    shift_reg[count] <= bus.rx_data_in;
                    count            <= count + CNT_W'(1);
                    if (count == CNT_W'(DATA_W - 1)) begin
                        state <= PARITY;
                    end
                end
                PARITY: begin
`ifdef RX_PARITY_CHECK_EN
                    parity_bit <= bus.rx_data_in;
`endif
                    state <= STOP;
                end
                STOP: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    // Load only when the holding register is free or being emptied now.
                    if (!bus.rx_valid || xfer_c) begin
                        bus.rx_data_out <= shift_reg;
                        bus.parity_err  <= parity_err_c;
                        bus.frame_err   <= !bus.rx_data_in;
                        bus.rx_valid    <= 1'b1;
                    end else begin
                        bus.overrun <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 SHALL have port tx_clk, input, 1 bit: baud-rate clock, one serial bit per rising edge, the same clock that drives the transmitter.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port rx_enable, input, 1 bit: permits start-bit detection.
REQ-004 SHALL have port rx_data_in, input, 1 bit: serial line, idle high.
REQ-005 SHALL have port rx_ready, input, 1 bit: consumer accepts the held byte.
REQ-006 SHALL have port rx_data_out, output, 8 bits: received byte, held.
REQ-007 SHALL have port rx_valid, output, 1 bit: rx_data_out and its status flags are valid.
REQ-008 SHALL have ports parity_err, frame_err and overrun, outputs, 1 bit each: status flags.
REQ-009 SHALL have port busy, output, 1 bit: frame in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-011 Frame format SHALL be: start (0), 8 data bits LSB first, parity bit (even: parity = XOR of the data bits), stop (1); one bit per tx_clk edge; no oversampling.
REQ-012 rx_data_in SHALL be sampled directly on each rising tx_clk edge, with no synchronizer, because the line is in the same clock domain.
REQ-013 The FSM SHALL have states IDLE, DATA, PARITY, STOP.
REQ-014 IDLE SHALL go to DATA at an edge where rx_enable=1 and rx_data_in=0; otherwise it SHALL stay in IDLE.
REQ-015 DATA SHALL shift rx_data_in into bit[count] using a 3-bit count of 0..7, and SHALL go to PARITY after count=7.
REQ-016 PARITY SHALL capture the parity bit and then go to STOP.
REQ-017 STOP SHALL sample the stop bit and then go to IDLE unconditionally.
REQ-018 At the STOP edge the block SHALL compute the frame's byte and status flags:
  - frame_err = (stop sample == 0);
  - parity_err = (captured parity != XOR of the data byte).
REQ-019 When the output register is free (REQ-020, REQ-021), the STOP edge SHALL load rx_data_out, parity_err and frame_err, set rx_valid=1 and pulse done=1 for one cycle.
  - Latency: rx_valid rises after the 11th sampling edge, counting the start sample as the 1st.
REQ-020 A transfer SHALL occur at an edge where rx_valid=1 and rx_ready=1; rx_valid SHALL then clear unless the same edge also loads a new frame.
REQ-021 If a frame completes while rx_valid=1 and no transfer occurs at that edge:
  - the new byte and its flags SHALL be discarded;
  - overrun SHALL set to 1;
  - done SHALL still pulse.
REQ-022 overrun SHALL be sticky until the next transfer, and SHALL clear at the edge where that transfer occurs.
REQ-023 If a frame completes at the same edge as a transfer, the new frame SHALL load, rx_valid SHALL stay 1 and overrun SHALL NOT set.
REQ-024 A frame with an error SHALL still be delivered, with its error flag valid alongside rx_valid.
REQ-025 rx_enable SHALL be examined only in IDLE; deasserting it mid-frame SHALL NOT abort the frame.
REQ-026 busy SHALL be 1 in DATA, PARITY and STOP, and 0 in IDLE.
REQ-027 The next start bit SHALL be detectable from IDLE on the edge immediately after STOP.
REQ-028 rx_data_out and the flags SHALL be stable while rx_valid=1 and no transfer occurs.

Reset
REQ-029 At an edge with rst_n=0 the block SHALL enter IDLE and clear count and the shift register.
REQ-030 At an edge with rst_n=0 every output SHALL take its reset value: rx_data_out=8'h00; rx_valid, parity_err, frame_err, overrun, busy and done all 0.
REQ-031 Reset mid-frame SHALL abort the frame without asserting rx_valid.

Configuration
REQ-032 Macro RX_PARITY_CHECK_EN defined: parity_err SHALL behave per REQ-018.
REQ-033 Macro RX_PARITY_CHECK_EN undefined:
  - the parity bit SHALL still be consumed in PARITY, so frame timing is unchanged;
  - parity_err SHALL be tied to 0.

Verification
REQ-034 Byte 0xA5, serial stream 0,1,0,1,0,0,1,0,1,0,1, rx_ready=1 -> rx_data_out=0xA5, rx_valid after the 11th edge, done pulse, all error flags 0.
REQ-035 Byte 0x01 sent with parity 0 instead of 1 -> rx_data_out=0x01, parity_err=1; with RX_PARITY_CHECK_EN undefined -> parity_err=0.
REQ-036 Byte 0x3C sent with stop bit 0 -> rx_data_out=0x3C, frame_err=1, FSM in IDLE on the next edge.
REQ-037 Two frames 0x11 then 0x22 with rx_ready=0 -> rx_data_out stays 0x11 and overrun=1; after one rx_ready=1 edge -> rx_valid=0 and overrun=0.
REQ-038 rst_n=0 after the 4th data bit, then 0xFF sent -> no rx_valid from the aborted frame; next rx_valid carries 0xFF.
REQ-039 rx_enable=0 with a low line -> stays in IDLE with busy=0; rx_enable dropped mid-frame -> frame completes normally.
